// File: rtl/pipelined_n_to_1_mux.sv
// pipelined_n_to_1_mux
// Two-stage registered N:1 multiplexer with valid/ready flow control.
// Stage 1 captures a lower-half and an upper-half candidate plus the
// select and valid bits. Stage 2 picks between the two halves using the
// select MSB.
// Define MUX_SCAN_EN to build an internal scan counter. When scan_mode=1,
// that counter supplies the select instead of selector_bits.
// NUM_INPUTS must be a power of two (2..256). DATA_WIDTH may be 1..64.

module pipelined_n_to_1_mux #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_WIDTH = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   input_lines,
  input  logic [$clog2(NUM_INPUTS)-1:0]      selector_bits,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               scan_mode,
  output logic [DATA_WIDTH-1:0]              output_line,
  output logic [$clog2(NUM_INPUTS)-1:0]      active_sel,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int SEL_WIDTH = $clog2(NUM_INPUTS);

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic                  en;
  logic                  accept;
  logic [SEL_WIDTH-1:0]  sel_used;

  // Stage 1 state
  logic [DATA_WIDTH-1:0] lo_data_reg, lo_data_next;
  logic [DATA_WIDTH-1:0] hi_data_reg, hi_data_next;
  logic [SEL_WIDTH-1:0]  s1_sel_reg,  s1_sel_next;
  logic                  s1_valid_reg, s1_valid_next;

  // Stage 2 (output) state
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic [SEL_WIDTH-1:0]  out_sel_reg,  out_sel_next;
  logic                  out_valid_reg, out_valid_next;

  // Candidates produced by the first-level half multiplexers
  logic [DATA_WIDTH-1:0] lo_pick;
  logic [DATA_WIDTH-1:0] hi_pick;

  // The pipeline advances whenever the output slot is empty or is being drained
  assign en       = !out_valid_reg || out_ready;
  assign in_ready = en;
  // A reset cycle never accepts a sample, even though in_ready may read 1
  assign accept   = in_valid && en && !reset;

  // ---------------------------------------------------------------------------
  // Unpack the flattened input bus into one entry per channel
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] channel [NUM_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign channel[gi] = input_lines[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Select source: optional scan counter or external selector_bits
  // ---------------------------------------------------------------------------
`ifdef MUX_SCAN_EN
  logic [SEL_WIDTH-1:0] scan_cnt_reg;
  logic [SEL_WIDTH-1:0] scan_cnt_next;

  // Counter steps once per accepted scan-mode transfer.
  // It wraps naturally because NUM_INPUTS is a power of two.
  always_comb begin
    scan_cnt_next = scan_cnt_reg;
    if (accept && scan_mode) begin
      scan_cnt_next = scan_cnt_reg + SEL_WIDTH'(1);
    end
  end

  // Scan counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_reg <= '0;
    end else begin
      scan_cnt_reg <= scan_cnt_next;
    end
  end

  assign sel_used = scan_mode ? scan_cnt_reg : selector_bits;
`else
  // scan_mode is kept on the port list but has no function in this build
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;
  assign sel_used         = selector_bits;
`endif

  // ---------------------------------------------------------------------------
  // First-level half multiplexers
  // ---------------------------------------------------------------------------
  generate
    if (NUM_INPUTS == 2) begin : g_two
      // Each half contains a single channel, so no lower select bits exist
      assign lo_pick = channel[0];
      assign hi_pick = channel[1];
    end else begin : g_halves
      logic [SEL_WIDTH-2:0] half_idx;
      assign half_idx = sel_used[SEL_WIDTH-2:0];
      assign lo_pick  = channel[{1'b0, half_idx}];
      assign hi_pick  = channel[{1'b1, half_idx}];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  // Stage 1 next state.
  // Bubbles clear valid, and data is only captured for real samples.
  always_comb begin
    s1_valid_next = s1_valid_reg;
    s1_sel_next   = s1_sel_reg;
    lo_data_next  = lo_data_reg;
    hi_data_next  = hi_data_reg;
    if (en) begin
      s1_valid_next = in_valid;
      if (in_valid) begin
        s1_sel_next  = sel_used;
        lo_data_next = lo_pick;
        hi_data_next = hi_pick;
      end
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_sel_reg   <= '0;
      lo_data_reg  <= '0;
      hi_data_reg  <= '0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s1_sel_reg   <= s1_sel_next;
      lo_data_reg  <= lo_data_next;
      hi_data_reg  <= hi_data_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------------
  // Stage 2 next state.
  // The select MSB chooses the half, and the select travels with the data.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_sel_next   = out_sel_reg;
    out_data_next  = out_data_reg;
    if (en) begin
      out_valid_next = s1_valid_reg;
      if (s1_valid_reg) begin
        out_sel_next  = s1_sel_reg;
        out_data_next = s1_sel_reg[SEL_WIDTH-1] ? hi_data_reg : lo_data_reg;
      end
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_sel_reg   <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_sel_reg   <= out_sel_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign output_line = out_data_reg;
  assign active_sel  = out_sel_reg;
  assign out_valid   = out_valid_reg;

endmodule
